// File: rtl/sevenseg_scan_ctrl_if.sv
// Load port of the seven-segment scan controller: a valid/ready handshake
// that carries the digit values, per-digit decimal points and the
// leading-zero blanking flag.
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic                    ready;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank_lz;

    modport master (
        output load,
        output value,
        output dp_mask,
        output blank_lz,
        input  ready
    );

    modport slave (
        input  load,
        input  value,
        input  dp_mask,
        input  blank_lz,
        output ready
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed N-digit common-anode seven-segment driver.
// One digit is driven at a time from a shared segment bus.  Each digit's
// dwell starts with a dark cycle to avoid ghosting, and PWM on the dwell
// tick sets brightness.  New values are staged in a pending slot and only
// move to the displayed set at a frame boundary (or at once while the
// display is disabled), so a single frame never mixes old and new digits.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 10_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int PWM_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PWM_BITS-1:0]   brightness,
    sevenseg_scan_ctrl_if.slave   ld,
    output logic [7:0]            seg_n,
    output logic [NUM_DIGITS-1:0] dig_en_n,
    output logic                  frame_done
);

    localparam int DWELL  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int TICK_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int VAL_W  = 4 * NUM_DIGITS;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // scan position
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    // displayed set
    logic [VAL_W-1:0]      act_value_q, act_value_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic                  act_blz_q, act_blz_d;
    // staged set
    logic [VAL_W-1:0]      pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_blz_q, pend_blz_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  ready_q, ready_d;
    // registered outputs
    logic [7:0]            seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0] dig_en_n_q, dig_en_n_d;
    logic                  frame_done_q, frame_done_d;

    logic                  accept_s;
    logic                  last_tick_s;
    logic                  last_dig_s;
    logic                  wrap_s;
    logic                  apply_s;
    logic [3:0]            nib_s;
    logic [NUM_DIGITS-1:0] blank_s;
    logic                  still_zero_s;
    logic [PWM_BITS-1:0]   phase_s;

    // Handshake, frame-boundary detection and scan counter advance
    always_comb begin
        accept_s    = ld.load & ready_q;
        last_tick_s = (tick_q == TICK_W'(DWELL - 1));
        last_dig_s  = (idx_q == IDX_W'(NUM_DIGITS - 1));
        wrap_s      = enable & last_tick_s & last_dig_s;
        // while dark there is no frame to tear, so apply straight away
        apply_s     = pend_valid_q & (wrap_s | ~enable);

        tick_d = tick_q;
        idx_d  = idx_q;
        if (!enable) begin
            tick_d = '0;
            idx_d  = '0;
        end else if (last_tick_s) begin
            tick_d = '0;
            if (last_dig_s) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            tick_d = tick_q + TICK_W'(1);
        end
    end

    // Pending slot capture and hand-over to the displayed set
    always_comb begin
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_blz_d   = pend_blz_q;
        pend_valid_d = pend_valid_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_blz_d    = act_blz_q;
        if (accept_s) begin
            pend_value_d = ld.value;
            pend_dp_d    = ld.dp_mask;
            pend_blz_d   = ld.blank_lz;
            pend_valid_d = 1'b1;
        end else if (apply_s) begin
            act_value_d  = pend_value_q;
            act_dp_d     = pend_dp_q;
            act_blz_d    = pend_blz_q;
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
        // drop ready immediately on accept so a back-to-back load is refused
        ready_d = ~pend_valid_q & ~accept_s;
    end

    // Segment decode, leading-zero blanking, PWM digit enable
    always_comb begin
        nib_s        = act_value_q[{idx_q, 2'b00} +: 4];
        phase_s      = tick_q[PWM_BITS-1:0];
        blank_s      = '0;
        still_zero_s = act_blz_q;
        // walk down from the most significant digit; digit 0 is never blanked
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            still_zero_s = still_zero_s & (act_value_q[4*k +: 4] == 4'h0);
            blank_s[k]   = still_zero_s;
        end

        seg_n_d      = 8'hFF;
        dig_en_n_d   = '1;
        frame_done_d = wrap_s;
        if (enable) begin
            if (blank_s[idx_q]) begin
                seg_n_d = {~act_dp_q[idx_q], 7'b1111111};
            end else begin
                seg_n_d = {~act_dp_q[idx_q], hex_to_seg(nib_s)};
            end
            // tick 0 is the anti-ghosting dead cycle
            if ((tick_q != '0) && (phase_s < brightness)) begin
                dig_en_n_d[idx_q] = 1'b0;
            end else begin
                dig_en_n_d = '1;
            end
        end else begin
            seg_n_d    = 8'hFF;
            dig_en_n_d = '1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q       <= '0;
            idx_q        <= '0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blz_q    <= 1'b0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blz_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            seg_n_q      <= 8'hFF;
            dig_en_n_q   <= '1;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_blz_q    <= act_blz_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_blz_q   <= pend_blz_d;
            pend_valid_q <= pend_valid_d;
            ready_q      <= ready_d;
            seg_n_q      <= seg_n_d;
            dig_en_n_q   <= dig_en_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dig_en_n   = dig_en_n_q;
    assign frame_done = frame_done_q;
    assign ld.ready   = ready_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: 4 digits, 16-cycle dwell, 2-bit PWM.
// A frame-position reference model predicts every output each cycle;
// directed sequences cover the listed scenarios, then random traffic runs.
module tb_sevenseg_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 16;
    localparam int FR = ND * DW;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable;
    logic [1:0] brightness;
    logic [7:0] seg_n;
    logic [3:0] dig_en_n;
    logic       frame_done;

    sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .CLK_HZ     (64000),
        .REFRESH_HZ (1000),
        .PWM_BITS   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .brightness (brightness),
        .ld         (bus.slave),
        .seg_n      (seg_n),
        .dig_en_n   (dig_en_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit sb_on    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected segment byte for digit d of a displayed set
    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp,
                                           input logic blz, input int d);
        logic [6:0] tab [16];
        int         msd;
        logic [3:0] nib;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        msd = 0;
        for (int k = 0; k < ND; k++) begin
            if (v[4*k +: 4] != 4'h0) msd = k;
        end
        nib = v[4*d +: 4];
        if (blz && d > msd) return {~dp[d], 7'h7F};
        return {~dp[d], tab[nib]};
    endfunction

    // reference model: position within the frame, displayed and staged sets
    int         m_pos;
    logic [15:0] m_act_val, m_pend_val;
    logic [3:0]  m_act_dp, m_pend_dp;
    logic        m_act_blz, m_pend_blz, m_pend_valid, m_ready;
    logic [7:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos <= 0;
            m_act_val <= 16'h0; m_act_dp <= 4'h0; m_act_blz <= 1'b0;
            m_pend_val <= 16'h0; m_pend_dp <= 4'h0; m_pend_blz <= 1'b0;
            m_pend_valid <= 1'b0; m_ready <= 1'b1;
            e_seg <= 8'hFF; e_dig <= 4'hF; e_fd <= 1'b0;
        end else begin
            e_fd <= enable && (m_pos == FR - 1);
            if (!enable) begin
                e_seg <= 8'hFF;
                e_dig <= 4'hF;
            end else begin
                e_seg <= exp_seg(m_act_val, m_act_dp, m_act_blz, m_pos / DW);
                e_dig <= (((m_pos % DW) != 0) && (((m_pos % DW) % 4) < int'(brightness)))
                         ? ~(4'b0001 << (m_pos / DW)) : 4'hF;
            end
            m_pos   <= enable ? (m_pos + 1) % FR : 0;
            m_ready <= !m_pend_valid && !(bus.load && m_ready);
            if (bus.load && m_ready) begin
                m_pend_val <= bus.value; m_pend_dp <= bus.dp_mask; m_pend_blz <= bus.blank_lz;
                m_pend_valid <= 1'b1;
            end else if (m_pend_valid && (!enable || m_pos == FR - 1)) begin
                m_act_val <= m_pend_val; m_act_dp <= m_pend_dp; m_act_blz <= m_pend_blz;
                m_pend_valid <= 1'b0;
            end
        end
    end

    // cycle-by-cycle scoreboard
    always @(negedge clk) begin
        if (sb_on) begin
            check_eq("seg_n", 32'(seg_n), 32'(e_seg));
            check_eq("dig_en_n", 32'(dig_en_n), 32'(e_dig));
            check_eq("frame_done", 32'(frame_done), 32'(e_fd));
            check_eq("ready", 32'(bus.ready), 32'(m_ready));
        end
    end

    int         o_cnt [ND];
    logic [7:0] o_seg [ND];
    int         o_fd_at;
    logic       o_rdy1;

    task automatic wait_fd(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("frame_done_seen", 32'(ok), 32'd1);
    endtask

    // watch one full frame starting from a frame_done negedge
    task automatic observe_frame();
        o_fd_at = 0;
        o_rdy1  = 1'b0;
        for (int k = 0; k < ND; k++) begin
            o_cnt[k] = 0;
            o_seg[k] = 8'h00;
        end
        for (int i = 1; i <= FR; i++) begin
            @(negedge clk);
            if (i == 1) o_rdy1 = bus.ready;
            for (int k = 0; k < ND; k++) begin
                if (!dig_en_n[k]) begin
                    o_cnt[k]++;
                    o_seg[k] = seg_n;
                end
            end
            if (frame_done && o_fd_at == 0) o_fd_at = i;
        end
        check_eq("frame_len", 32'(o_fd_at), 32'(FR));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic blz);
        bus.load = 1'b1; bus.value = v; bus.dp_mask = dp; bus.blank_lz = blz;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        int steps;
        enable = 1'b0; brightness = 2'd3;
        bus.load = 1'b0; bus.value = 16'h0; bus.dp_mask = 4'h0; bus.blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_seg", 32'(seg_n), 32'hFF);
        check_eq("rst_dig", 32'(dig_en_n), 32'hF);
        check_eq("rst_ready", 32'(bus.ready), 32'd1);
        check_eq("rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        sb_on = 1'b1;

        // asynchronous reset in the middle of a scan with a load pending
        enable = 1'b1;
        repeat (20) @(negedge clk);
        do_load(16'hBEEF, 4'h5, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_rst_seg", 32'(seg_n), 32'hFF);
        check_eq("async_rst_dig", 32'(dig_en_n), 32'hF);
        check_eq("async_rst_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // basic display of 12AF at full PWM level
        do_load(16'h12AF, 4'h0, 1'b0);
        wait_fd(200);
        observe_frame();
        check_eq("d0_seg_F", 32'(o_seg[0]), 32'h8E);
        check_eq("d1_seg_A", 32'(o_seg[1]), 32'h88);
        check_eq("d2_seg_2", 32'(o_seg[2]), 32'hA4);
        check_eq("d3_seg_1", 32'(o_seg[3]), 32'hF9);
        for (int k = 0; k < ND; k++) check_eq("lit_cnt_b3", 32'(o_cnt[k]), 32'd11);

        // tearing: second load while pending must be refused
        repeat (20) @(negedge clk);
        check_eq("ready_before", 32'(bus.ready), 32'd1);
        bus.load = 1'b1; bus.value = 16'h1111;
        @(negedge clk);
        check_eq("ready_after_acc", 32'(bus.ready), 32'd0);
        bus.value = 16'h2222;
        @(negedge clk);
        bus.load = 1'b0;
        wait_fd(200);
        check_eq("ready_at_fd", 32'(bus.ready), 32'd0);
        observe_frame();
        check_eq("ready_after_fd", 32'(o_rdy1), 32'd1);
        for (int k = 0; k < ND; k++) check_eq("seg_ones", 32'(o_seg[k]), 32'hF9);

        // leading-zero blanking with DP on the blanked MSD
        do_load(16'h0040, 4'b1000, 1'b1);
        wait_fd(200);
        observe_frame();
        check_eq("blz_d3", 32'(o_seg[3]), 32'h7F);
        check_eq("blz_d2", 32'(o_seg[2]), 32'hFF);
        check_eq("blz_d1", 32'(o_seg[1]), 32'h99);
        check_eq("blz_d0", 32'(o_seg[0]), 32'hC0);
        do_load(16'h0000, 4'b1000, 1'b1);
        wait_fd(200);
        observe_frame();
        check_eq("blz0_d3", 32'(o_seg[3]), 32'h7F);
        check_eq("blz0_d2", 32'(o_seg[2]), 32'hFF);
        check_eq("blz0_d1", 32'(o_seg[1]), 32'hFF);
        check_eq("blz0_d0", 32'(o_seg[0]), 32'hC0);

        // brightness 0: dark all frame, frame pulses continue
        brightness = 2'd0;
        observe_frame();
        for (int k = 0; k < ND; k++) check_eq("lit_cnt_b0", 32'(o_cnt[k]), 32'd0);
        brightness = 2'd3;

        // disable mid-frame, load while dark, restart
        repeat (10) @(negedge clk);
        enable = 1'b0;
        bus.load = 1'b1; bus.value = 16'hABCD; bus.dp_mask = 4'h0; bus.blank_lz = 1'b0;
        @(negedge clk);
        bus.load = 1'b0;
        check_eq("dis_dark", 32'(dig_en_n), 32'hF);
        repeat (2) @(negedge clk);
        check_eq("dis_ready", 32'(bus.ready), 32'd1);
        enable = 1'b1;
        steps = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (frame_done) begin
                steps = i;
                break;
            end
        end
        check_eq("restart_fd", 32'(steps), 32'(FR));

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.load = ($urandom_range(0, 7) == 0);
            bus.value = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'h00FF : 16'hFFFF);
            bus.dp_mask = 4'($urandom);
            bus.blank_lz = 1'($urandom);
            if ($urandom_range(0, 49) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if (i == 1500) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
            end
            @(negedge clk);
            rst_n = 1'b1;
        end
        bus.load = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
